// File: rtl/stopwatch_display_if.sv
// Display bus between the stopwatch counters (master) and the multiplexed
// 8-digit seven-segment scanner (slave).
interface stopwatch_display_if;
    logic       blankEnIn;
    logic [3:0] milliBcdOneIn;
    logic [3:0] milliBcdTenIn;
    logic [3:0] milliBcdHundredIn;
    logic [3:0] secondBcdOneIn;
    logic [3:0] secondBcdTenIn;
    logic [3:0] minuteBcdOneIn;
    logic [3:0] minuteBcdTenIn;
    logic [3:0] hourBcdOneIn;
    logic [7:0] anodeOut;
    logic [6:0] segmentOut;
    logic       dpOut;
    logic       frameStartOut;

    modport master (
        output blankEnIn, milliBcdOneIn, milliBcdTenIn, milliBcdHundredIn, secondBcdOneIn,
               secondBcdTenIn, minuteBcdOneIn, minuteBcdTenIn, hourBcdOneIn,
        input  anodeOut, segmentOut, dpOut, frameStartOut
    );

    modport slave (
        input  blankEnIn, milliBcdOneIn, milliBcdTenIn, milliBcdHundredIn, secondBcdOneIn,
               secondBcdTenIn, minuteBcdOneIn, minuteBcdTenIn, hourBcdOneIn,
        output anodeOut, segmentOut, dpOut, frameStartOut
    );
endinterface

// File: rtl/stopwatch_display.sv
// Eight-digit multiplexed seven-segment scanner: snapshots all digits once per
// frame, then walks idx 0..7 with a dark gap before each digit's dwell.
module stopwatch_display #(
    parameter int DWELL_COUNT = 12500,
    parameter int GAP_COUNT   = 16
) (
    input logic                clkIn,
    input logic                rstIn,
    stopwatch_display_if.slave disp
);
    localparam int MAXC = (DWELL_COUNT > GAP_COUNT) ? DWELL_COUNT : GAP_COUNT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {SNAP, GAP, DWELL} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      idx, idx_nx;
    logic            enter_dwell, leave_dwell;
    logic [7:0][3:0] shadow;
    logic            shadow_blank;
    logic [7:0]      blank;
    logic            run;
    logic [7:0]      anode_q;
    logic [6:0]      seg_q;
    logic            dp_q;

    // 10 shows as 0 because carry logic upstream passes through it briefly
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0, 4'd10: decode = 7'h40;
            4'd1:        decode = 7'h79;
            4'd2:        decode = 7'h24;
            4'd3:        decode = 7'h30;
            4'd4:        decode = 7'h19;
            4'd5:        decode = 7'h12;
            4'd6:        decode = 7'h02;
            4'd7:        decode = 7'h78;
            4'd8:        decode = 7'h00;
            4'd9:        decode = 7'h10;
            default:     decode = 7'h3F;
        endcase
    endfunction

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state <= SNAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        enter_dwell = 1'b0;
        leave_dwell = 1'b0;
        case (state)
            SNAP: begin
                state_nx = GAP;
                cnt_nx   = '0;
            end
            GAP: begin
                if (cnt == CW'(GAP_COUNT - 1)) begin
                    state_nx    = DWELL;
                    cnt_nx      = '0;
                    enter_dwell = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DWELL: begin
                if (cnt == CW'(DWELL_COUNT - 1)) begin
                    leave_dwell = 1'b1;
                    cnt_nx      = '0;
                    if (idx == 3'd7) begin
                        state_nx = SNAP;
                        idx_nx   = '0;
                    end else begin
                        state_nx = GAP;
                        idx_nx   = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = SNAP;
        endcase
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            shadow       <= '0;
            shadow_blank <= 1'b0;
        end else if (state == SNAP) begin
            shadow <= {disp.hourBcdOneIn, disp.minuteBcdTenIn, disp.minuteBcdOneIn,
                       disp.secondBcdTenIn, disp.secondBcdOneIn, disp.milliBcdHundredIn,
                       disp.milliBcdTenIn, disp.milliBcdOneIn};
            shadow_blank <= disp.blankEnIn;
        end
    end

    // A high digit is blanked only while it and everything above it reads zero
    always_comb begin
        blank = '0;
        run   = shadow_blank;
        for (int k = 7; k >= 4; k--) begin
            run      = run & (decode(shadow[k]) == 7'h40);
            blank[k] = run;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            anode_q <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else if (enter_dwell) begin
            if (blank[idx]) begin
                anode_q <= 8'hFF;
                seg_q   <= 7'h7F;
                dp_q    <= 1'b1;
            end else begin
                anode_q <= ~(8'd1 << idx);
                seg_q   <= decode(shadow[idx]);
                dp_q    <= !(idx == 3'd3 || idx == 3'd5);
            end
        end else if (leave_dwell) begin
            anode_q <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end
    end

    assign disp.anodeOut      = anode_q;
    assign disp.segmentOut    = seg_q;
    assign disp.dpOut         = dp_q;
    assign disp.frameStartOut = (state == SNAP) && !rstIn;
endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display with DWELL_COUNT=4, GAP_COUNT=2
// (49-cycle frames); expected display samples are queued per frame.
module tb_stopwatch_display;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        int         frame;
        int         smp;
    } exp_t;

    exp_t q[$];

    stopwatch_display_if dif();

    stopwatch_display #(.DWELL_COUNT(4), .GAP_COUNT(2)) dut (
        .clkIn (clk),
        .rstIn (rst),
        .disp  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [7:0] an, input logic [6:0] seg, input logic dp,
                        input logic fs, input int frame, input int smp);
        exp_t e;
        e.an = an; e.seg = seg; e.dp = dp; e.fs = fs; e.frame = frame; e.smp = smp;
        q.push_back(e);
    endtask

    // segs[k] is the hand-decoded code for idx k; dpl marks dp-low digits
    task automatic push_frame(input int frame, input logic [7:0][6:0] segs,
                              input logic [7:0] dpl, input logic [7:0] blk, input int limit);
        int n;
        n = 0;
        if (n < limit) push(8'hFF, 7'h7F, 1'b1, 1'b1, frame, n);
        n++;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < 2; g++) begin
                if (n < limit) push(8'hFF, 7'h7F, 1'b1, 1'b0, frame, n);
                n++;
            end
            for (int d = 0; d < 4; d++) begin
                if (n < limit) begin
                    if (blk[k]) push(8'hFF, 7'h7F, 1'b1, 1'b0, frame, n);
                    else        push(~(8'd1 << k), segs[k], ~dpl[k], 1'b0, frame, n);
                end
                n++;
            end
        end
    endtask

    task automatic set_digits(input logic [7:0][3:0] d, input logic blank_en);
        dif.milliBcdOneIn     = d[0];
        dif.milliBcdTenIn     = d[1];
        dif.milliBcdHundredIn = d[2];
        dif.secondBcdOneIn    = d[3];
        dif.secondBcdTenIn    = d[4];
        dif.minuteBcdOneIn    = d[5];
        dif.minuteBcdTenIn    = d[6];
        dif.hourBcdOneIn      = d[7];
        dif.blankEnIn         = blank_en;
    endtask

    always @(negedge clk) begin
        exp_t e;
        total++;
        if ($countones(~dif.anodeOut) > 1) begin
            bad++;
            $display("FAIL onehot_anode: anodeOut=%h has more than one low bit", dif.anodeOut);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (dif.anodeOut !== e.an || dif.segmentOut !== e.seg ||
                dif.dpOut !== e.dp || dif.frameStartOut !== e.fs) begin
                bad++;
                $display("FAIL frame%0d_s%0d: got an=%h seg=%h dp=%b fs=%b want an=%h seg=%h dp=%b fs=%b",
                         e.frame, e.smp, dif.anodeOut, dif.segmentOut, dif.dpOut,
                         dif.frameStartOut, e.an, e.seg, e.dp, e.fs);
            end
        end
    end

    localparam logic [7:0] DP35 = 8'b0010_1000;

    initial begin
        rst = 1'b1;
        set_digits({4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 1'b0);
        @(posedge clk); #1;
        push(8'hFF, 7'h7F, 1'b1, 1'b0, 90, 0);
        push(8'hFF, 7'h7F, 1'b1, 1'b0, 90, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // frame 0: plain scan of 1..8
        push_frame(0, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, DP35, 8'h00, 49);
        repeat (49) @(posedge clk);
        #1;

        // frame 1: input changes mid-frame must not show until the next snapshot
        push_frame(1, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, DP35, 8'h00, 49);
        repeat (17) @(posedge clk);
        #1 dif.milliBcdOneIn = 4'd7;
        repeat (32) @(posedge clk);
        #1;

        push_frame(2, {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h78}, DP35, 8'h00, 49);
        repeat (49) @(posedge clk);
        #1;

        // frame 3: hours/minutes zero -> top three blanked, low zeros kept
        set_digits({4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd10, 4'd9, 4'd0}, 1'b1);
        push_frame(3, {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40, 7'h10, 7'h40},
                   8'b0000_1000, 8'b1110_0000, 49);
        repeat (49) @(posedge clk);
        #1;

        // frame 4: 10 counts as zero for blanking, 11..15 are dashes
        set_digits({4'd0, 4'd10, 4'd12, 4'd0, 4'd3, 4'd11, 4'd15, 4'd12}, 1'b1);
        push_frame(4, {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h30, 7'h3F, 7'h3F, 7'h3F},
                   DP35, 8'b1100_0000, 49);
        repeat (49) @(posedge clk);
        #1;

        // frame 5: all tens, no blanking
        set_digits({8{4'd10}}, 1'b0);
        push_frame(5, {8{7'h40}}, DP35, 8'h00, 49);
        repeat (49) @(posedge clk);
        #1;

        // frame 6: reset lands inside idx 4 dwell
        push_frame(6, {8{7'h40}}, DP35, 8'h00, 28);
        repeat (28) @(posedge clk);
        #1 rst = 1'b1;
        push(8'hFF, 7'h7F, 1'b1, 1'b0, 91, 0);
        push(8'hFF, 7'h7F, 1'b1, 1'b0, 91, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        push_frame(7, {8{7'h40}}, DP35, 8'h00, 49);
        repeat (49) @(posedge clk);
        #1;

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
